uart_tx_queue: RTL and testbench

Buffered UART transmit engine for the debugger's host link. Accepts bytes from on-chip logic through a write strobe into a FIFO and serializes them onto the host TX pin as 8N1 frames at a fixed baud rate. It carries probe/response traffic back to the host and is the return direction of the command path that receives bytes on the RX pin. Runs entirely on the board clock; no dependency on the receive side.

---
 rtl/uart_tx_queue.sv | 108 ++++++++++
 tb/tb_uart_tx_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding an 8N1 UART transmitter with back-to-back framing
module uart_tx_queue #(
  parameter int BAUD_RATE    = 9600,
  parameter int SYS_CLK_FREQ = 12000000,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                           iCE_CLK,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [7:0]                     wr_data,
  output logic                           full,
  output logic                           overflow,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           tx,
  output logic                           is_transmitting
);
  localparam int CPB = SYS_CLK_FREQ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, overflow_q, tx_q, tx_d;
  logic          push, pop, bit_end;

  // Full is judged on the registered flag, so a same-cycle pop never frees room for this write.
  assign push    = wr_en && !full_q;
  assign bit_end = cnt_q == CNT_MAX;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

  // Next-state: bit timing, shifting and pops; tx is derived from the next state so it stays registered.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + CW'(1);
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        shift_d = mem_q[rd_ptr_q];
        state_d = START;
      end
      START: if (bit_end) begin
        bit_d   = 3'd0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        pop     = count_q != '0;
        shift_d = pop ? mem_q[rd_ptr_q] : shift_q;
        state_d = pop ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
  end

  // Control state, FIFO pointers and registered outputs.
  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_q + AW'(push);
      rd_ptr_q   <= rd_ptr_q + AW'(pop);
      count_q    <= count_d;
      full_q     <= count_d == (AW+1)'(FIFO_DEPTH);
      overflow_q <= wr_en && full_q;
      tx_q       <= tx_d;
    end
  end

  // FIFO storage captures the byte at push time.
  always_ff @(posedge iCE_CLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full            = full_q;
  assign overflow        = overflow_q;
  assign fifo_count      = count_q;
  assign tx              = tx_q;
  assign is_transmitting = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed and randomized checks of the queued UART transmitter
module tb_uart_tx_queue;
  localparam int CPB = 16;

  logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, overflow, tx, is_tx;
  logic [3:0] fifo_count;

  uart_tx_queue #(.BAUD_RATE(1), .SYS_CLK_FREQ(16), .FIFO_DEPTH(8)) dut (
    .iCE_CLK(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .overflow(overflow), .fifo_count(fifo_count), .tx(tx), .is_transmitting(is_tx)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, frame_err = 0, ovf_cnt = 0;
  logic [7:0] rx_q[$], exp_q[$];
  int start_q[$];
  bit in_f = 0;
  int c, k;
  logic [7:0] sh;

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: finds start edges, samples mid-bit, records bytes and start times.
  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt++;
    if (!rst_n) in_f = 0;
    else if (!in_f) begin
      if (tx === 1'b0) begin
        in_f = 1; c = 0; sh = '0;
        start_q.push_back(cyc);
      end
    end else begin
      c++;
      if (c % CPB == CPB / 2) begin
        k = c / CPB;
        if (k >= 1 && k <= 8) sh[k-1] = tx;
        if (k == 9) begin
          if (tx !== 1'b1) frame_err++;
          rx_q.push_back(sh);
        end
      end
      if (c == CPB / 2 && tx !== 1'b0) frame_err++;
      if (c == 10 * CPB - 1) in_f = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic fb(input logic [7:0] b, input int bi);
    return bi == 0 ? 1'b0 : bi == 9 ? 1'b1 : b[bi-1];
  endfunction

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0; wr_data = 8'($urandom);
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_q.size() < n && t < 20000) begin @(negedge clk); t++; end
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic drain_cmp();
    while (exp_q.size() > 0 && rx_q.size() > 0) chk("rx_byte", rx_q.pop_front(), exp_q.pop_front());
    chk("rx_leftover", exp_q.size() + rx_q.size(), 0);
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((is_tx || fifo_count != 0) && t < 20000) begin @(negedge clk); t++; end
    chk("idle_busy", is_tx, 0);
    chk("idle_count", fifo_count, 0);
  endtask

  initial begin
    logic [7:0] b;
    int t;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", is_tx, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tx", tx, 1);

    push(8'h55);
    exp_q.push_back(8'h55);
    chk("single_count", fifo_count, 1);
    chk("single_busy0", is_tx, 0);
    chk("single_tx0", tx, 1);
    @(negedge clk);
    chk("single_count_pop", fifo_count, 0);
    for (int j = 0; j < 10 * CPB; j++) begin
      chk("single_tx", tx, fb(8'h55, j / CPB));
      chk("single_busy", is_tx, 1);
      @(negedge clk);
    end
    chk("single_end_busy", is_tx, 0);
    chk("single_end_tx", tx, 1);
    wait_rx(1);
    drain_cmp();

    start_q.delete();
    push(8'hA5); chk("b2b_count1", fifo_count, 1);
    push(8'h0F);
    push(8'hFF); chk("b2b_count3", fifo_count, 2);
    exp_q = '{8'hA5, 8'h0F, 8'hFF};
    wait_rx(3);
    drain_cmp();
    chk("b2b_starts", start_q.size(), 3);
    if (start_q.size() == 3) begin
      chk("b2b_gap1", start_q[1] - start_q[0], 10 * CPB);
      chk("b2b_gap2", start_q[2] - start_q[1], 10 * CPB);
    end
    wait_idle();

    ovf_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      push(8'(i));
      if (i < 9) exp_q.push_back(8'(i));
    end
    chk("ovf_pulse", overflow, 1);
    chk("ovf_full", full, 1);
    chk("ovf_count", fifo_count, 8);
    @(negedge clk);
    chk("ovf_single", overflow, 0);
    chk("ovf_full_hold", full, 1);
    wait_rx(9);
    drain_cmp();
    wait_idle();
    chk("ovf_full_clear", full, 0);
    chk("ovf_pulses", ovf_cnt, 1);

    ovf_cnt = 0;
    for (int r = 0; r < 4; r++) begin
      t = 0;
      while (fifo_count > 3 && t < 5000) begin @(negedge clk); t++; end
      repeat ($urandom_range(0, 40)) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push(b);
      end
    end
    wait_rx(20);
    drain_cmp();
    wait_idle();
    chk("wrap_no_ovf", ovf_cnt, 0);

    push(8'h3C);
    push(8'h11);
    push(8'h22);
    chk("mid_count", fifo_count, 2);
    repeat (70) @(negedge clk);
    chk("mid_bit3", tx, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", is_tx, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_full", full, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      chk("after_rst_tx", tx, 1);
      chk("after_rst_busy", is_tx, 0);
    end
    chk("after_rst_rx", rx_q.size(), 0);
    b = 8'($urandom);
    exp_q.push_back(b);
    push(b);
    wait_rx(1);
    drain_cmp();
    wait_idle();
    chk("frame_errors", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
